// File: rtl/spidergon_pkg.sv
// Shared spidergon definitions: flit type codes, node port indices, width helper.
package spidergon_pkg;

   localparam logic [1:0] HEAD_FLIT = 2'b01;
   localparam logic [1:0] HEADER    = 2'b11;
   localparam logic [1:0] BODY_FLIT = 2'b10;
   localparam logic [1:0] TAIL_FLIT = 2'b00;

   localparam int PORT_CW     = 0;
   localparam int PORT_ACW    = 1;
   localparam int PORT_ACROSS = 2;
   localparam int PORT_LOCAL  = 3;

   localparam int HEAD_TAIL = 2;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot pick starting at the pointer,
// pointer registered and moved past the winner only when i_advance is set.
module rr_arbiter
   import spidergon_pkg::*;
#(
   parameter  int N  = 8,
   localparam int IW = clog2_min1(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  i_req,
   input  logic          i_advance,
   output logic [N-1:0]  o_gnt,
   output logic [IW-1:0] o_idx,
   output logic          o_any
);

   logic [IW-1:0] r_ptr;
   logic [IW-1:0] w_cand;

   // Scan downward so the candidate closest to the pointer is the last one kept.
   always_comb begin
      o_any  = 1'b0;
      o_idx  = '0;
      o_gnt  = '0;
      w_cand = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_cand = IW'((int'(r_ptr) + k) % N);
         if (i_req[w_cand]) begin
            o_any = 1'b1;
            o_idx = w_cand;
         end
      end
      if (o_any) o_gnt[o_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (i_advance && o_any) begin
         r_ptr <= (o_idx == IW'(N - 1)) ? '0 : o_idx + 1'b1;
      end
   end

endmodule

// File: rtl/spidergon_vc_allocator.sv
// Output-VC allocator for one router output port; one registered grant per cycle.
// VC_ALLOC_RELEASE_BYPASS_EN lets a VC released this cycle be re-granted in the same decision.
module spidergon_vc_allocator
   import spidergon_pkg::*;
#(
   parameter  int NUM_OF_INPUT_PORTS      = 4,
   parameter  int NUM_OF_VIRTUAL_CHANNELS = 2,
   localparam int NUM_REQ = NUM_OF_INPUT_PORTS * NUM_OF_VIRTUAL_CHANNELS,
   localparam int VC_W    = clog2_min1(NUM_OF_VIRTUAL_CHANNELS),
   localparam int OWN_W   = clog2_min1(NUM_REQ)
) (
   input  logic                                       clk,
   input  logic                                       reset,
   input  logic [NUM_REQ-1:0]                         req,
   output logic                                       gnt_valid,
   output logic [NUM_REQ-1:0]                         gnt,
   output logic [VC_W-1:0]                            gnt_vc,
   input  logic                                       release_valid,
   input  logic [VC_W-1:0]                            release_vc,
   output logic [NUM_OF_VIRTUAL_CHANNELS-1:0]         vc_busy,
   output logic [NUM_OF_VIRTUAL_CHANNELS*OWN_W-1:0]   vc_owner,
   output logic                                       release_err
);

   localparam int              NVC   = NUM_OF_VIRTUAL_CHANNELS;
   localparam logic [VC_W:0]   NVC_L = (VC_W + 1)'(NVC);

   logic [NVC-1:0]     r_vc_busy;
   logic [OWN_W-1:0]   r_vc_owner [NVC];
   logic               r_gnt_valid;
   logic [NUM_REQ-1:0] r_gnt;
   logic [VC_W-1:0]    r_gnt_vc;
   logic               r_release_err;

   logic               w_rel_in_range;
   logic               w_rel_hit;
   logic [NVC-1:0]     w_busy_view;
   logic [NUM_REQ-1:0] w_owned;
   logic [NUM_REQ-1:0] w_eligible;
   logic [NUM_REQ-1:0] w_arb_gnt;
   logic [OWN_W-1:0]   w_winner;
   logic               w_arb_any;
   logic               w_free_any;
   logic [VC_W-1:0]    w_free_vc;
   logic               w_grant;

   // A release only counts when it names an existing VC that is actually reserved.
   assign w_rel_in_range = {1'b0, release_vc} < NVC_L;
   assign w_rel_hit      = release_valid && w_rel_in_range && r_vc_busy[release_vc];

   always_comb begin
      w_busy_view = r_vc_busy;
`ifdef VC_ALLOC_RELEASE_BYPASS_EN
      if (w_rel_hit) w_busy_view[release_vc] = 1'b0;
`endif
   end

   // Requesters that already own a VC are masked so each (port, vc) has one packet in flight.
   always_comb begin
      w_owned = '0;
      for (int v = 0; v < NVC; v++) begin
         if (w_busy_view[v]) w_owned[r_vc_owner[v]] = 1'b1;
      end
   end

   assign w_eligible = req & ~w_owned;

   always_comb begin
      w_free_any = 1'b0;
      w_free_vc  = '0;
      for (int v = NVC - 1; v >= 0; v--) begin
         if (!w_busy_view[v]) begin
            w_free_any = 1'b1;
            w_free_vc  = VC_W'(v);
         end
      end
   end

   assign w_grant = w_arb_any && w_free_any;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk       (clk),
      .reset     (reset),
      .i_req     (w_eligible),
      .i_advance (w_grant),
      .o_gnt     (w_arb_gnt),
      .o_idx     (w_winner),
      .o_any     (w_arb_any)
   );

   // Release is applied before the grant so a bypassed VC can be reclaimed on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vc_busy     <= '0;
         r_gnt_valid   <= 1'b0;
         r_gnt         <= '0;
         r_gnt_vc      <= '0;
         r_release_err <= 1'b0;
         for (int v = 0; v < NVC; v++) r_vc_owner[v] <= '0;
      end else begin
         r_gnt_valid <= w_grant;
         r_gnt       <= w_grant ? w_arb_gnt : '0;
         r_gnt_vc    <= w_grant ? w_free_vc : '0;
         if (release_valid && !w_rel_hit) r_release_err <= 1'b1;
         if (w_rel_hit) r_vc_busy[release_vc] <= 1'b0;
         if (w_grant) begin
            r_vc_busy[w_free_vc]  <= 1'b1;
            r_vc_owner[w_free_vc] <= w_winner;
         end
      end
   end

   assign gnt_valid   = r_gnt_valid;
   assign gnt         = r_gnt;
   assign gnt_vc      = r_gnt_vc;
   assign vc_busy     = r_vc_busy;
   assign release_err = r_release_err;

   for (genvar g = 0; g < NVC; g++) begin : g_owner
      assign vc_owner[g*OWN_W +: OWN_W] = r_vc_owner[g];
   end

endmodule

// File: tb/tb_spidergon_vc_allocator.sv
// Bench for spidergon_vc_allocator: directed vectors, literal checks plus a per-cycle reference model.
module tb_spidergon_vc_allocator;

   localparam int NREQ = 8;
   localparam int NVC  = 2;
   localparam int OW   = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [NREQ-1:0] req;
   logic            gnt_valid;
   logic [NREQ-1:0] gnt;
   logic [0:0]      gnt_vc;
   logic            release_valid;
   logic [0:0]      release_vc;
   logic [NVC-1:0]  vc_busy;
   logic [NVC*OW-1:0] vc_owner;
   logic            release_err;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spidergon_vc_allocator #(
      .NUM_OF_INPUT_PORTS      (4),
      .NUM_OF_VIRTUAL_CHANNELS (2)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .req           (req),
      .gnt_valid     (gnt_valid),
      .gnt           (gnt),
      .gnt_vc        (gnt_vc),
      .release_valid (release_valid),
      .release_vc    (release_vc),
      .vc_busy       (vc_busy),
      .vc_owner      (vc_owner),
      .release_err   (release_err)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: reservation table, RR pointer and expected registered grant.
   bit  m_busy [NVC];
   int  m_owner [NVC];
   int  m_ptr;
   bit  m_err;
   bit  e_gv;
   int  e_gnt;
   int  e_vc;
   bit  started = 1'b0;
   bit  view [NVC];
   bit  rel_ok;
   bit  owned;
   int  fv, win, cand;
   logic [NVC-1:0] e_busy;

   always @(posedge clk) begin
      started = 1'b1;
      if (reset) begin
         for (int v = 0; v < NVC; v++) begin
            m_busy[v]  = 1'b0;
            m_owner[v] = 0;
         end
         m_ptr = 0; m_err = 1'b0; e_gv = 1'b0; e_gnt = 0; e_vc = 0;
      end else begin
         view   = m_busy;
         rel_ok = release_valid && (int'(release_vc) < NVC) && m_busy[release_vc];
`ifdef VC_ALLOC_RELEASE_BYPASS_EN
         if (rel_ok) view[release_vc] = 1'b0;
`endif
         fv = -1;
         for (int v = 0; v < NVC; v++) if (!view[v] && fv < 0) fv = v;
         win = -1;
         for (int k = 0; k < NREQ; k++) begin
            cand  = (m_ptr + k) % NREQ;
            owned = 1'b0;
            for (int v = 0; v < NVC; v++) if (view[v] && m_owner[v] == cand) owned = 1'b1;
            if (req[cand] && !owned && win < 0) win = cand;
         end
         if (release_valid && !rel_ok) m_err = 1'b1;
         if (rel_ok) m_busy[release_vc] = 1'b0;
         e_gv = 1'b0; e_gnt = 0; e_vc = 0;
         if (fv >= 0 && win >= 0) begin
            m_busy[fv]  = 1'b1;
            m_owner[fv] = win;
            m_ptr       = (win + 1) % NREQ;
            e_gv = 1'b1; e_gnt = 1 << win; e_vc = fv;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int v = 0; v < NVC; v++) e_busy[v] = m_busy[v];
         chk("model_gnt_valid", {31'b0, gnt_valid}, {31'b0, e_gv});
         chk("model_gnt", {24'b0, gnt}, e_gnt);
         if (e_gv) chk("model_gnt_vc", {31'b0, gnt_vc}, e_vc);
         chk("model_vc_busy", {30'b0, vc_busy}, {30'b0, e_busy});
         for (int v = 0; v < NVC; v++)
            if (m_busy[v]) chk("model_vc_owner", {29'b0, vc_owner[v*OW +: OW]}, m_owner[v]);
         chk("model_release_err", {31'b0, release_err}, {31'b0, m_err});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      reset = 1'b1; req = '0; release_valid = 1'b0; release_vc = '0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req = '0; release_valid = 1'b0; release_vc = '0;
      tick(); tick();
      chk("rst_gnt_valid", {31'b0, gnt_valid}, 0);
      chk("rst_gnt", {24'b0, gnt}, 0);
      chk("rst_vc_busy", {30'b0, vc_busy}, 0);
      chk("rst_vc_owner", {26'b0, vc_owner}, 0);
      chk("rst_release_err", {31'b0, release_err}, 0);
      reset = 1'b0;

      // Single request: requester 1 gets vc0 one cycle later.
      req = 8'b0000_0010;
      tick();
      chk("t1_gnt_valid", {31'b0, gnt_valid}, 1);
      chk("t1_gnt", {24'b0, gnt}, 32'h02);
      chk("t1_gnt_vc", {31'b0, gnt_vc}, 0);
      chk("t1_vc_busy", {30'b0, vc_busy}, 32'b01);
      chk("t1_owner0", {29'b0, vc_owner[2:0]}, 1);
      req = '0;

      // Two held requesters fill both VCs, a third waits.
      pulse_reset();
      req = 8'b0000_0110;
      tick();
      chk("t2_first_gnt", {24'b0, gnt}, 32'h02);
      chk("t2_first_vc", {31'b0, gnt_vc}, 0);
      tick();
      chk("t2_second_gnt", {24'b0, gnt}, 32'h04);
      chk("t2_second_vc", {31'b0, gnt_vc}, 1);
      req = 8'b0010_0110;
      tick();
      chk("t2_full_gnt_valid", {31'b0, gnt_valid}, 0);
      chk("t2_full_vc_busy", {30'b0, vc_busy}, 32'b11);
      tick();
      chk("t2_still_waiting", {31'b0, gnt_valid}, 0);

      // Release vc0 in cycle N: waiting requester 5 takes it.
      release_valid = 1'b1; release_vc = 1'b0;
      tick();
      release_valid = 1'b0;
`ifdef VC_ALLOC_RELEASE_BYPASS_EN
      chk("t3_n1_gnt_valid", {31'b0, gnt_valid}, 1);
      chk("t3_n1_gnt", {24'b0, gnt}, 32'h20);
      chk("t3_n1_gnt_vc", {31'b0, gnt_vc}, 0);
`else
      chk("t3_n1_gnt_valid", {31'b0, gnt_valid}, 0);
      chk("t3_n1_vc_busy", {30'b0, vc_busy}, 32'b10);
`endif
      tick();
`ifdef VC_ALLOC_RELEASE_BYPASS_EN
      chk("t3_n2_gnt_valid", {31'b0, gnt_valid}, 0);
`else
      chk("t3_n2_gnt_valid", {31'b0, gnt_valid}, 1);
      chk("t3_n2_gnt", {24'b0, gnt}, 32'h20);
      chk("t3_n2_gnt_vc", {31'b0, gnt_vc}, 0);
`endif
      chk("t3_owner0", {29'b0, vc_owner[2:0]}, 5);
      req = '0;

      // All requesters held with immediate releases: strict round-robin order.
      pulse_reset();
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         tick();
         chk("t4_rr_gnt_valid", {31'b0, gnt_valid}, 1);
         chk("t4_rr_order", {24'b0, gnt}, 32'(1 << (k % 8)));
         release_valid = 1'b1;
         release_vc    = gnt_vc;
      end
      req = '0;
      tick();
      release_valid = 1'b0;
      chk("t4_drained_busy", {30'b0, vc_busy}, 0);

      // Release on an idle VC sets the sticky error flag.
      release_valid = 1'b1; release_vc = 1'b1;
      tick();
      release_valid = 1'b0;
      chk("t5_err_set", {31'b0, release_err}, 1);
      chk("t5_busy_unchanged", {30'b0, vc_busy}, 0);
      tick(); tick();
      chk("t5_err_sticky", {31'b0, release_err}, 1);

      // Reset in the middle of traffic clears everything.
      req = 8'h0F;
      tick(); tick();
      reset = 1'b1;
      tick();
      chk("t6_gnt_valid", {31'b0, gnt_valid}, 0);
      chk("t6_gnt", {24'b0, gnt}, 0);
      chk("t6_vc_busy", {30'b0, vc_busy}, 0);
      chk("t6_vc_owner", {26'b0, vc_owner}, 0);
      chk("t6_release_err", {31'b0, release_err}, 0);
      reset = 1'b0; req = '0;
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spidergon_vc_allocator.md
Name: spidergon_vc_allocator

Overview:
- Output-VC allocator for one output port of a spidergon router node (clockwise, anti-clockwise, across or local).
- Arbitrates head/header-flit requests from every (input port, input VC) pair and reserves one free output VC per packet.
- Holds each reservation until the owning packet's tail flit is released.
- Instantiated once per output port inside each router of spidergon_top.

Parameters:
- NUM_OF_INPUT_PORTS, 4, input ports per node (cw, acw, across, local).
- NUM_OF_VIRTUAL_CHANNELS, 2, VCs per port, both input and output side.
- NUM_REQ (localparam), NUM_OF_INPUT_PORTS*NUM_OF_VIRTUAL_CHANNELS, number of requesters; requester index = port*NUM_OF_VIRTUAL_CHANNELS + vc.
- VC_W (localparam), max(1,$clog2(NUM_OF_VIRTUAL_CHANNELS)), width of a VC index.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- req, input, NUM_REQ, per-requester head-flit request for this output port; level, held until granted.
- gnt_valid, output, 1, a grant was issued this cycle.
- gnt, output, NUM_REQ, one-hot granted requester (all zero when gnt_valid=0).
- gnt_vc, output, VC_W, output VC reserved for the granted requester.
- release_valid, input, 1, tail flit (or single-flit HEADER packet) has left on release_vc.
- release_vc, input, VC_W, output VC to free.
- vc_busy, output, NUM_OF_VIRTUAL_CHANNELS, reservation status per output VC.
- vc_owner, output, NUM_OF_VIRTUAL_CHANNELS*$clog2(NUM_REQ), flattened owner index per output VC; valid only where vc_busy=1.
- release_err, output, 1, sticky flag: release_valid was seen on a VC that was not busy.

Behaviour:
- Reset values: gnt_valid=0, gnt=0, gnt_vc=0, vc_busy=0, vc_owner=0, release_err=0, RR pointer=0. reset overrides every input in the same cycle, including a mid-packet reset: all reservations are dropped.
- Eligible requester: req[i]=1 and i is not the current owner of any busy VC. A requester that already holds a VC is masked, so each (port, vc) has at most one packet in flight.
- Grant cycle: if any eligible requester exists and at least one output VC is free:
  - winner = first eligible index at or after the RR pointer, wrapping modulo NUM_REQ;
  - chosen VC = lowest-index free VC.
- Grant outputs are registered, latency 1: req sampled in cycle N gives gnt/gnt_vc/gnt_valid in cycle N+1.
- In the same edge, vc_busy[chosen]=1 and vc_owner[chosen]=winner.
- At most one grant per cycle.
- RR pointer moves to (winner+1) mod NUM_REQ, only on a grant.
- All VCs busy: no grant, pointer holds, requests wait with no timeout.
- Release: release_valid clears vc_busy[release_vc] at the clock edge. The freed VC is not grantable until the following cycle (no bypass), so release in N → earliest re-grant visible in N+2.
- Release on a non-busy VC: no state change, release_err=1 until reset.
- Release and grant in the same cycle always target distinct VCs, because the grant only sees VCs that were free at the start of the cycle.
- release_vc ≥ NUM_OF_VIRTUAL_CHANNELS: treated as an error and flags release_err.
- The requester deasserts req after gnt. If req stays high after gnt, the owner mask blocks any second grant.

Optional Feature:
- Macro: VC_ALLOC_RELEASE_BYPASS_EN.
- Defined: a VC freed by release_valid in cycle N is eligible for the grant decision in cycle N, so the re-grant is visible in N+1. Chosen VC is still the lowest-index free one after applying the release. The owner mask also uses the post-release state, so a releasing requester may be re-granted immediately.
- Undefined: no-bypass behaviour above.

Decomposition:
- Shared package spidergon_pkg holds:
  - flit type constants HEAD_FLIT=2'b01, HEADER=2'b11, BODY_FLIT=2'b10, TAIL_FLIT=2'b00;
  - port index constants PORT_CW=0, PORT_ACW=1, PORT_ACROSS=2, PORT_LOCAL=3;
  - HEAD_TAIL=2.
- One sub-module, rr_arbiter: parameterised N-way round-robin, combinational one-hot pick plus registered pointer with an advance enable. Reused later by the switch allocator.

Test Plan:
- After reset, req=8'b0000_0010 → next cycle gnt_valid=1, gnt=8'b0000_0010, gnt_vc=0, vc_busy=2'b01, vc_owner[0]=1.
- req=8'b0000_0110 held → grants to requester 1 (vc0), then requester 2 (vc1) one cycle later. A third requester, 5, then waits with vc_busy=2'b11 and gnt_valid=0.
- vc0 owned by 1, requester 5 waiting, release_valid=1, release_vc=0 in cycle N → without bypass gnt to 5 on vc0 in N+2; with VC_ALLOC_RELEASE_BYPASS_EN in N+1.
- All 8 requesters held high with repeated immediate releases → grant order 0,1,…,7,0 with no requester granted twice within 8 grants.
- release_valid on idle vc1 → release_err=1 and stays 1, vc_busy unchanged. Assert reset for one cycle mid-traffic → all outputs return to 0 the next cycle.
